// File: rtl/morse_pkg.sv
// Shared encodings and ASCII constants for the Morse message sequencer.
package morse_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_CHAR_GAP  = 3'd3;
    localparam logic [2:0] ST_WORD_GAP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SEND      = ST_SEND,
        WAIT_DONE = ST_WAIT_DONE,
        CHAR_GAP  = ST_CHAR_GAP,
        WORD_GAP  = ST_WORD_GAP
    } state_t;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_Z)
            return c - CASE_OFFSET;
        return c;
    endfunction

endpackage

// File: rtl/morse_fifo.sv
// Single-clock show-ahead byte FIFO; rdata is always the current head.
module morse_fifo
    import morse_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (FIFO_AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Queues ASCII bytes and paces them into morse_generator with Morse gap timing.
// Optional MORSE_SEQ_CASE_FOLD_EN folds lowercase to uppercase on the way out.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int MORSE_CYCLES   = 2,
    parameter int FIFO_AW        = 4,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [7:0]         data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [7:0]         gen_ascii_o,
    output logic               gen_en_o,
    input  logic               gen_done_i,
    output logic               busy_o,
    output logic [FIFO_AW:0]   fifo_count_o
);

    localparam int TW = $clog2(WORD_GAP_UNITS * MORSE_CYCLES) + 1;
    localparam logic [TW-1:0] CHAR_LOAD = TW'(CHAR_GAP_UNITS * MORSE_CYCLES - 1);
    // The char gap already elapsed before the space was popped, so only the remainder is added.
    localparam logic [TW-1:0] WORD_LOAD = TW'((WORD_GAP_UNITS - CHAR_GAP_UNITS) * MORSE_CYCLES - 1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [7:0]      head;
    logic [7:0]      head_out;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign ready_o = !full;
    assign push    = valid_i && ready_o;
    assign pop     = (state == IDLE) && !empty;
    assign busy_o  = (state != IDLE) || !empty;

`ifdef MORSE_SEQ_CASE_FOLD_EN
    assign head_out = fold_case(head);
`else
    assign head_out = head;
`endif

    morse_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (push),
        .pop   (pop),
        .wdata (data_i),
        .rdata (head),
        .count (fifo_count_o),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            timer       <= '0;
            gen_ascii_o <= '0;
            gen_en_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head == ASCII_SPACE) begin
                            timer <= WORD_LOAD;
                            state <= WORD_GAP;
                        end else begin
                            gen_ascii_o <= head_out;
                            gen_en_o    <= 1'b1;
                            state       <= SEND;
                        end
                    end
                end
                SEND: begin
                    gen_en_o <= 1'b0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (gen_done_i) begin
                        timer <= CHAR_LOAD;
                        state <= CHAR_GAP;
                    end
                end
                CHAR_GAP, WORD_GAP: begin
                    if (timer == '0)
                        state <= IDLE;
                    else
                        timer <= timer - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer with a small generator model driving gen_done_i.
module tb_morse_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] gen_ascii_o;
    logic       gen_en_o;
    logic       gen_done_i = 1'b0;
    logic       busy_o;
    logic [4:0] fifo_count_o;

    morse_sequencer #(
        .MORSE_CYCLES(2), .FIFO_AW(4), .CHAR_GAP_UNITS(3), .WORD_GAP_UNITS(7)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .gen_ascii_o(gen_ascii_o), .gen_en_o(gen_en_o),
        .gen_done_i(gen_done_i), .busy_o(busy_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0, checks = 0;
    int cyc = 0, en_count = 0, last_en_edge = -1, done_edge = -1, push_edge = 0;
    int gen_lat = 3;
    bit gen_block = 1'b0, prev_en = 1'b0;
    logic [7:0] sb [$];

    function automatic logic [7:0] expect_of(input logic [7:0] b);
`ifdef MORSE_SEQ_CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // edge counter: at any negedge, cyc is the index of the last rising edge
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // generator model: done pulse gen_lat cycles after en, held off while gen_block
    initial forever begin
        @(negedge clk_i);
        if (gen_en_o) begin
            repeat (gen_lat - 1) @(negedge clk_i);
            while (gen_block) @(negedge clk_i);
            gen_done_i = 1'b1;
            done_edge  = cyc + 1;
            @(negedge clk_i);
            gen_done_i = 1'b0;
        end
    end

    // monitor: every start pulse consumes one scoreboard entry
    initial forever begin
        logic [7:0] exp;
        @(negedge clk_i);
        if (gen_en_o) begin
            en_count++;
            last_en_edge = cyc;
            chk("en_single_cycle", int'(prev_en), 0);
            chk("ascii_not_space", int'(gen_ascii_o == 8'h20), 0);
            chk("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("gen_ascii", int'(gen_ascii_o), int'(exp));
            end
        end
        prev_en = gen_en_o;
    end

    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        data_i  = b;
        valid_i = 1'b1;
        while (!ready_o && t < 400) begin
            @(negedge clk_i);
            t++;
        end
        if (!ready_o) begin
            chk("push_ready_timeout", 0, 1);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        push_edge = cyc;
        valid_i   = 1'b0;
        if (b != 8'h20) sb.push_back(expect_of(b));
    endtask

    task automatic wait_en(input int target);
        int t = 0;
        while (en_count < target && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (en_count < target) chk("en_timeout", en_count, target);
    endtask

    task automatic wait_done(output int d);
        int t = 0;
        while (done_edge < 0 && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (done_edge < 0) chk("done_timeout", 0, 1);
        d = done_edge;
    endtask

    task automatic wait_edge(input int k);
        @(negedge clk_i);
        while (cyc < k) @(negedge clk_i);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk_i);
        while (busy_o && t < 1000) begin
            @(negedge clk_i);
            t++;
        end
        chk("idle_reached", int'(busy_o), 0);
    endtask

    initial begin
        int base, d;
        repeat (3) @(negedge clk_i);
        chk("rst_en", int'(gen_en_o), 0);
        chk("rst_ascii", int'(gen_ascii_o), 0);
        chk("rst_count", int'(fifo_count_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready", int'(ready_o), 1);
        chk("post_rst_busy", int'(busy_o), 0);

        // single character: latency, gap length, return to idle
        base = en_count;
        done_edge = -1;
        push_byte(8'h41);
        wait_en(base + 1);
        chk("a_latency", last_en_edge, push_edge + 1);
        wait_done(d);
        wait_edge(d + 5);
        chk("a_gap_busy", int'(busy_o), 1);
        @(negedge clk_i);
        chk("a_idle_busy", int'(busy_o), 0);

        // "E E": space becomes a word gap
        base = en_count;
        done_edge = -1;
        push_byte(8'h45);
        push_byte(8'h20);
        push_byte(8'h45);
        wait_en(base + 1);
        wait_done(d);
        wait_en(base + 2);
        chk("word_gap_edge", last_en_edge, d + 16);
        wait_idle();

        // simultaneous push/pop at count 1, plus lowercase handling
        base = en_count;
        push_byte(8'h61);
        push_byte(8'h5A);
        chk("simul_count", int'(fifo_count_o), 1);
        wait_en(base + 2);
        wait_idle();
        chk("sb_drained_1", sb.size(), 0);

        // overflow: generator stalled, FIFO fills to depth
        gen_block = 1'b1;
        base = en_count;
        for (int i = 0; i < 17; i++) push_byte(8'h41 + 8'(i));
        chk("full_count", int'(fifo_count_o), 16);
        chk("full_ready", int'(ready_o), 0);
        fork
            push_byte(8'h5A);
            begin
                repeat (5) @(negedge clk_i);
                chk("full_hold_count", int'(fifo_count_o), 16);
                chk("full_hold_ready", int'(ready_o), 0);
                gen_block = 1'b0;
            end
        join
        chk("refill_count", int'(fifo_count_o), 16);
        wait_en(base + 18);
        wait_idle();
        chk("sb_drained_2", sb.size(), 0);

        // reset while waiting on the generator with 5 bytes queued
        gen_block = 1'b1;
        base = en_count;
        for (int i = 0; i < 6; i++) push_byte(8'h30 + 8'(i));
        wait_en(base + 1);
        chk("pre_rst_count", int'(fifo_count_o), 5);
        #2 reset_i = 1'b1;
        #1;
        chk("mid_rst_en", int'(gen_en_o), 0);
        chk("mid_rst_ascii", int'(gen_ascii_o), 0);
        chk("mid_rst_count", int'(fifo_count_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        sb.delete();
        @(negedge clk_i);
        reset_i   = 1'b0;
        gen_block = 1'b0;
        base = en_count;
        repeat (30) @(negedge clk_i);
        chk("no_en_after_rst", en_count, base);
        chk("ready_after_rst", int'(ready_o), 1);

        // recovery after reset
        push_byte(8'h4B);
        wait_en(base + 1);
        wait_idle();
        chk("sb_drained_3", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
